// File: rtl/conv_engine_param_pkg.sv
// Shared types for the parametrised 1-D convolution engine.
package conv_engine_param_pkg;

  // Output shape selection; the reserved code behaves as full.
  typedef enum logic [1:0] {
    SHAPE_FULL  = 2'b00,
    SHAPE_SAME  = 2'b01,
    SHAPE_VALID = 2'b10,
    SHAPE_RSVD  = 2'b11
  } shape_e;

  // Job sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ISSUE = 3'd2,
    ST_LAST  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Accumulator width that can hold a full-length dot product without overflow.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned aw);
    return 2 * dw + aw;
  endfunction

endpackage

// File: rtl/conv_engine_param_mac.sv
// Registered DW x DW multiply-accumulate with clear and enable.
module conv_engine_param_mac #(
  parameter int unsigned DW     = 8,
  parameter int unsigned ACC_W  = 21,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [ACC_W-1:0] sum_c
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned XW = ACC_W - PW;

  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    b_ext;
  logic [PW-1:0]    prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc;

  // Operand and product extension chosen by signedness; low 2*DW bits of the
  // extended product are exact in both modes.
  if (SIGNED) begin : g_signed
    assign a_ext    = {{DW{a[DW-1]}}, a};
    assign b_ext    = {{DW{b[DW-1]}}, b};
    assign prod_ext = {{XW{prod[PW-1]}}, prod};
  end else begin : g_unsigned
    assign a_ext    = {{DW{1'b0}}, a};
    assign b_ext    = {{DW{1'b0}}, b};
    assign prod_ext = {{XW{1'b0}}, prod};
  end

  assign prod  = a_ext * b_ext;
  assign sum_c = acc + prod_ext;

  // Accumulator register: clear has priority over accumulate.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= sum_c;
  end

endmodule

// File: rtl/conv_engine_param.sv
// Output-stationary 1-D convolution engine (full/same/valid) over external X/Y memories.
module conv_engine_param
  import conv_engine_param_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 5,
  parameter bit          SIGNED = 1'b0,
  parameter int unsigned ACC_W  = acc_width(DW, AW)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [1:0]       shape,
  input  logic [AW-1:0]    size_x,
  input  logic [AW-1:0]    size_y,
  input  logic [DW-1:0]    data_x,
  input  logic [DW-1:0]    data_y,
  output logic [AW-1:0]    mem_x_addr,
  output logic [AW-1:0]    mem_y_addr,
  output logic [AW:0]      mem_z_addr,
  output logic [ACC_W-1:0] data_z,
  output logic             we_z,
  output logic             busy,
  output logic             done
);

  localparam int unsigned   IW  = AW + 1;
  localparam logic [IW-1:0] ONE = IW'(1);
  localparam logic [IW-1:0] TWO = IW'(2);

  state_e           state;
  logic [IW-1:0]    sx_q, sy_q;
  logic [IW-1:0]    n, n0, n1, k;
  logic             first_q;

  logic [IW-1:0]    sx_in, sy_in;
  logic [IW-1:0]    n0_c, n1_c, kmin0_c, kmax_c, n_nx_c, kmin_nx_c;
  logic             skip_c;
  logic             mac_clr_c, mac_en_c;
  logic [ACC_W-1:0] mac_sum_c;

  // First contributing k for output n.
  function automatic logic [IW-1:0] kmin_of(input logic [IW-1:0] nn, input logic [IW-1:0] sy);
    if (nn + ONE >= sy) return nn + ONE - sy;
    else                return '0;
  endfunction

  // Last contributing k for output n.
  function automatic logic [IW-1:0] kmax_of(input logic [IW-1:0] nn, input logic [IW-1:0] sx);
    if (nn + ONE < sx) return nn;
    else               return sx - ONE;
  endfunction

  // Output range and first-word bounds derived from the job inputs during SETUP.
  always_comb begin
    sx_in  = IW'(size_x);
    sy_in  = IW'(size_y);
    n0_c   = '0;
    n1_c   = sx_in + sy_in - TWO;
    skip_c = (size_x == '0) || (size_y == '0);
    case (shape_e'(shape))
      SHAPE_SAME: begin
        n0_c = sy_in >> 1;
        n1_c = n0_c + sx_in - ONE;
      end
      SHAPE_VALID: begin
        n0_c   = sy_in - ONE;
        n1_c   = sx_in - ONE;
        skip_c = skip_c || (sx_in < sy_in);
      end
      default: ;
    endcase
    kmin0_c   = kmin_of(n0_c, sy_in);
    kmax_c    = kmax_of(n, sx_q);
    n_nx_c    = n + ONE;
    kmin_nx_c = kmin_of(n_nx_c, sy_q);
  end

  // MAC control: first issue of a word clears, later issues and LAST accumulate.
  always_comb begin
    mac_clr_c = (state == ST_ISSUE) && first_q;
    mac_en_c  = ((state == ST_ISSUE) && !first_q) || (state == ST_LAST);
  end

  conv_engine_param_mac #(
    .DW     (DW),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mac (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (mac_clr_c),
    .en    (mac_en_c),
    .a     (data_x),
    .b     (data_y),
    .sum_c (mac_sum_c)
  );

  // Job sequencer with registered memory addresses, write port and status.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      sx_q       <= '0;
      sy_q       <= '0;
      n          <= '0;
      n0         <= '0;
      n1         <= '0;
      k          <= '0;
      first_q    <= 1'b0;
      mem_x_addr <= '0;
      mem_y_addr <= '0;
      mem_z_addr <= '0;
      data_z     <= '0;
      we_z       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SETUP;
            busy  <= 1'b1;
          end
        end
        ST_SETUP: begin
          sx_q <= sx_in;
          sy_q <= sy_in;
          if (skip_c) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state      <= ST_ISSUE;
            n          <= n0_c;
            n0         <= n0_c;
            n1         <= n1_c;
            k          <= kmin0_c;
            first_q    <= 1'b1;
            mem_x_addr <= AW'(kmin0_c);
            mem_y_addr <= AW'(n0_c - kmin0_c);
          end
        end
        ST_ISSUE: begin
          first_q <= 1'b0;
          if (k == kmax_c) begin
            state <= ST_LAST;
          end else begin
            k          <= k + ONE;
            mem_x_addr <= AW'(k + ONE);
            mem_y_addr <= AW'(n - k - ONE);
          end
        end
        ST_LAST: begin
          state      <= ST_WRITE;
          we_z       <= 1'b1;
          data_z     <= mac_sum_c;
          mem_z_addr <= n - n0;
        end
        ST_WRITE: begin
          we_z   <= 1'b0;
          data_z <= '0;
          if (n == n1) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state      <= ST_ISSUE;
            n          <= n_nx_c;
            k          <= kmin_nx_c;
            first_q    <= 1'b1;
            mem_x_addr <= AW'(kmin_nx_c);
            mem_y_addr <= AW'(n_nx_c - kmin_nx_c);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          we_z  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_engine_param.sv
// Directed and model-checked bench for conv_engine_param (unsigned and signed instances).
module tb_conv_engine_param;
  import conv_engine_param_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 5;
  localparam int unsigned ACC_W = 21;

  typedef struct packed {
    logic [1:0]             shape;
    logic [4:0]             sx;
    logic [4:0]             sy;
    logic                   sgn;
    logic [3:0][7:0]        x;
    logic [3:0][7:0]        y;
    logic [2:0]             nexp;
    logic [3:0][ACC_W-1:0]  e;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic [1:0] shape = 2'b00;
  logic [AW-1:0] size_x = '0;
  logic [AW-1:0] size_y = '0;
  logic sel = 1'b0;

  logic [DW-1:0] dx_u, dy_u, dx_s, dy_s;
  logic [AW-1:0] ax_u, ay_u, ax_s, ay_s;
  logic [AW:0] az_u, az_s;
  logic [ACC_W-1:0] dz_u, dz_s;
  logic we_u, we_s, busy_u, busy_s, done_u, done_s;

  logic [DW-1:0] mem_x [32];
  logic [DW-1:0] mem_y [32];

  logic v_we, v_busy, v_done;
  logic [AW:0] v_az;
  logic [ACC_W-1:0] v_dz;

  int n_vec = 0;
  int n_miss = 0;

  logic [ACC_W-1:0] got_data [$];
  logic [AW:0] got_addr [$];
  logic [ACC_W-1:0] exp_q [$];
  int first_we, last_we, done_at, busy_first, busy_last, busy_cnt, after_act, zero_viol;
  bit timed_out;

  vec_t vecs [11];

  always #5 clk = ~clk;

  // Registered-read X/Y memories, one read port per instance.
  always @(posedge clk) begin
    dx_u <= mem_x[ax_u];
    dy_u <= mem_y[ay_u];
    dx_s <= mem_x[ax_s];
    dy_s <= mem_y[ay_s];
  end

  assign v_we   = sel ? we_s   : we_u;
  assign v_busy = sel ? busy_s : busy_u;
  assign v_done = sel ? done_s : done_u;
  assign v_az   = sel ? az_s   : az_u;
  assign v_dz   = sel ? dz_s   : dz_u;

  conv_engine_param #(.DW(DW), .AW(AW), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rstn(rstn), .start(start), .shape(shape), .size_x(size_x), .size_y(size_y),
    .data_x(dx_u), .data_y(dy_u), .mem_x_addr(ax_u), .mem_y_addr(ay_u), .mem_z_addr(az_u),
    .data_z(dz_u), .we_z(we_u), .busy(busy_u), .done(done_u)
  );

  conv_engine_param #(.DW(DW), .AW(AW), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rstn(rstn), .start(start), .shape(shape), .size_x(size_x), .size_y(size_y),
    .data_x(dx_s), .data_y(dy_s), .mem_x_addr(ax_s), .mem_y_addr(ay_s), .mem_z_addr(az_s),
    .data_z(dz_s), .we_z(we_s), .busy(busy_s), .done(done_s)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] sh, input int sx, input int sy, input logic sg,
                              input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2,
                              input logic [7:0] x3, input logic [7:0] y0, input logic [7:0] y1,
                              input logic [7:0] y2, input logic [7:0] y3, input int ne,
                              input logic [ACC_W-1:0] e0, input logic [ACC_W-1:0] e1,
                              input logic [ACC_W-1:0] e2, input logic [ACC_W-1:0] e3);
    vec_t v;
    v.shape = sh; v.sx = 5'(sx); v.sy = 5'(sy); v.sgn = sg;
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
    v.y[0] = y0; v.y[1] = y1; v.y[2] = y2; v.y[3] = y3;
    v.nexp = 3'(ne);
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
    return v;
  endfunction

  task automatic load_vec(input vec_t v);
    shape = v.shape; size_x = v.sx; size_y = v.sy; sel = v.sgn;
    for (int i = 0; i < 32; i++) begin mem_x[i] = '0; mem_y[i] = '0; end
    for (int i = 0; i < 4; i++) begin mem_x[i] = v.x[i]; mem_y[i] = v.y[i]; end
    exp_q.delete();
    for (int i = 0; i < int'(v.nexp); i++) exp_q.push_back(v.e[i]);
  endtask

  function automatic longint sval(input logic [7:0] b, input logic sg);
    if (sg) return longint'($signed(b));
    else    return longint'(b);
  endfunction

  // Direct convolution reference over the current memories and job inputs.
  task automatic build_model();
    int sx, sy, sh, n0, n1;
    longint s;
    sx = int'(size_x); sy = int'(size_y); sh = (shape == 2'b11) ? 0 : int'(shape);
    exp_q.delete();
    if (sx == 0 || sy == 0 || (sh == 2 && sx < sy)) return;
    n0 = 0; n1 = sx + sy - 2;
    if (sh == 1) begin n0 = sy / 2; n1 = n0 + sx - 1; end
    if (sh == 2) begin n0 = sy - 1; n1 = sx - 1; end
    for (int n = n0; n <= n1; n++) begin
      s = 0;
      for (int kk = 0; kk < sx; kk++)
        if (n - kk >= 0 && n - kk < sy) s += sval(mem_x[kk], sel) * sval(mem_y[n - kk], sel);
      exp_q.push_back(ACC_W'(s));
    end
  endtask

  // Start one job (cycle 0 = start high), record writes and status per cycle.
  task automatic run_job(input int restart_at, input int budget);
    int c;
    got_data.delete(); got_addr.delete();
    first_we = -1; last_we = -1; done_at = -1; busy_first = -1; busy_last = -1;
    busy_cnt = 0; after_act = 0; zero_viol = 0; timed_out = 1'b0;
    @(posedge clk); #1; start = 1'b1;
    c = 0;
    forever begin
      @(negedge clk);
      if (done_at < 0) begin
        if (v_we) begin
          got_data.push_back(v_dz); got_addr.push_back(v_az);
          if (first_we < 0) first_we = c;
          last_we = c;
        end else if (v_dz != '0) zero_viol++;
        if (v_busy) begin
          busy_cnt++;
          if (busy_first < 0) busy_first = c;
          busy_last = c;
        end
        if (v_done) done_at = c;
      end else if (v_we || v_busy || v_done) after_act++;
      if (done_at >= 0 && c >= done_at + 3) break;
      if (c >= budget) begin timed_out = 1'b1; break; end
      @(posedge clk); #1; c++;
      start = (c == restart_at);
    end
    start = 1'b0;
  endtask

  task automatic check_words(input string nm);
    chk($sformatf("%s.timeout", nm), 64'(timed_out), 64'd0);
    chk($sformatf("%s.count", nm), 64'(got_data.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_data.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s.addr%0d", nm, i), 64'(got_addr[i]), 64'(i));
      chk($sformatf("%s.data%0d", nm, i), 64'(got_data[i]), 64'(exp_q[i]));
    end
    chk($sformatf("%s.done_at", nm), 64'(done_at),
        64'((exp_q.size() > 0) ? last_we + 1 : 2));
    chk($sformatf("%s.after", nm), 64'(after_act), 64'd0);
    chk($sformatf("%s.dz_idle", nm), 64'(zero_viol), 64'd0);
  endtask

  initial begin
    vecs[0]  = mk(2'b00, 3, 2, 1'b0, 1, 2, 3, 0, 1, 1, 0, 0, 4, 1, 3, 5, 3);
    vecs[1]  = mk(2'b01, 4, 3, 1'b0, 1, 2, 3, 4, 1, 1, 1, 0, 4, 3, 6, 9, 7);
    vecs[2]  = mk(2'b10, 4, 3, 1'b0, 1, 2, 3, 4, 1, 1, 1, 0, 2, 6, 9, 0, 0);
    vecs[3]  = mk(2'b10, 2, 3, 1'b0, 1, 2, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(2'b00, 0, 2, 1'b0, 1, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(2'b01, 3, 0, 1'b0, 1, 2, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(2'b00, 2, 1, 1'b1, 8'h80, 8'h7F, 0, 0, 8'h80, 0, 0, 0, 2,
                  21'h004000, 21'h1FC080, 0, 0);
    vecs[7]  = mk(2'b11, 2, 1, 1'b0, 2, 3, 0, 0, 4, 0, 0, 0, 2, 8, 12, 0, 0);
    vecs[8]  = mk(2'b00, 2, 2, 1'b0, 8'hFF, 8'hFF, 0, 0, 8'hFF, 8'hFF, 0, 0, 3,
                  65025, 130050, 65025, 0);
    vecs[9]  = mk(2'b10, 3, 3, 1'b0, 1, 2, 3, 0, 3, 2, 1, 0, 1, 14, 0, 0, 0);
    vecs[10] = mk(2'b01, 3, 2, 1'b1, 8'hFF, 2, 8'hFD, 0, 1, 8'hFF, 0, 0, 3,
                  3, 21'h1FFFFB, 3, 0);

    // Reset state of both instances.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_u", 64'({we_u, busy_u, done_u, ax_u, ay_u, az_u, dz_u}), 64'd0);
    chk("reset_s", 64'({we_s, busy_s, done_s, ax_s, ay_s, az_s, dz_s}), 64'd0);
    @(negedge clk); rstn = 1'b1;

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      load_vec(vecs[i]);
      run_job(-1, 300);
      check_words($sformatf("vec%0d", i));
    end

    // Latency and busy window, with a start pulse in the middle of the job.
    load_vec(vecs[0]);
    run_job(5, 300);
    check_words("midstart");
    chk("first_we", 64'(first_we), 64'd4);
    chk("done_cyc", 64'(done_at), 64'd16);
    chk("busy_first", 64'(busy_first), 64'd1);
    chk("busy_last", 64'(busy_last), 64'd15);

    // Start pulsed in the DONE cycle must not launch another job.
    load_vec(vecs[0]);
    run_job(16, 300);
    check_words("donestart");

    // Skipped job: done in cycle 2, busy only in cycle 1.
    load_vec(vecs[3]);
    run_job(-1, 50);
    chk("skip.done", 64'(done_at), 64'd2);
    chk("skip.busy_cnt", 64'(busy_cnt), 64'd1);
    chk("skip.busy_first", 64'(busy_first), 64'd1);

    // Asynchronous reset in ISSUE, then a clean job.
    load_vec(vecs[0]);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; rstn = 1'b0;
    #1;
    chk("rst_mid_u", 64'({we_u, busy_u, done_u, ax_u, ay_u, az_u, dz_u}), 64'd0);
    chk("rst_mid_s", 64'({we_s, busy_s, done_s, ax_s, ay_s, az_s, dz_s}), 64'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold", 64'({we_u, busy_u, we_s, busy_s}), 64'd0);
    rstn = 1'b1;
    run_job(-1, 300);
    check_words("after_rst");

    // Maximum lengths, maximum unsigned data.
    shape = 2'b00; size_x = 5'd31; size_y = 5'd31; sel = 1'b0;
    for (int i = 0; i < 32; i++) begin mem_x[i] = 8'hFF; mem_y[i] = 8'hFF; end
    build_model();
    run_job(-1, 5000);
    check_words("maxlen");
    chk("maxlen.centre", 64'((got_data.size() > 30) ? got_data[30] : '0), 64'd2015775);

    // Random jobs against the reference model.
    for (int r = 0; r < 12; r++) begin
      int sx, sy, t;
      sx = $urandom_range(1, 31); sy = $urandom_range(1, 31);
      shape = 2'($urandom_range(0, 3));
      if (shape == 2'b10 && (r % 3) != 0 && sy > sx) begin t = sx; sx = sy; sy = t; end
      size_x = 5'(sx); size_y = 5'(sy); sel = 1'($urandom_range(0, 1));
      for (int i = 0; i < 32; i++) begin
        mem_x[i] = 8'($urandom); mem_y[i] = 8'($urandom);
      end
      build_model();
      run_job(-1, 5000);
      check_words($sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
